// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous SRAM between an
// instruction-fetch port (I, read-only) and a data port (D, read/write).
// Grants are combinational; read data comes back one cycle after the grant
// and is routed to the port that issued the read.
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN to replace fixed D priority
// (with I starvation override) by alternating priority on conflicts.
module mem_port_arbiter #(
  parameter int AW           = 12,
  parameter int DW           = 32,
  parameter int BEW          = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  // instruction fetch port
  input  logic           i_req,
  input  logic [AW-1:0]  i_addr,
  output logic           i_gnt,
  output logic           i_rvalid,
  output logic [DW-1:0]  i_rdata,
  // data port
  input  logic           d_req,
  input  logic           d_we,
  input  logic [BEW-1:0] d_be,
  input  logic [AW-1:0]  d_addr,
  input  logic [DW-1:0]  d_wdata,
  output logic           d_gnt,
  output logic           d_rvalid,
  output logic [DW-1:0]  d_rdata,
  // SRAM macro side
  output logic           sram_csn,
  output logic           sram_wen,
  output logic [AW-1:0]  sram_addr,
  output logic [BEW-1:0] sram_be,
  output logic [DW-1:0]  sram_di,
  input  logic [DW-1:0]  sram_dout,
  // pipeline control
  output logic           stall_if
);

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    RESP_I = 2'd1,
    RESP_D = 2'd2
  } resp_e;

  resp_e owner_q, owner_d;
  logic  i_prio;   // I wins a conflict this cycle

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // last_d_q = 1 when D won the most recent conflict; resets to "I won",
  // so D takes the first conflict after reset.
  logic last_d_q, last_d_d;

  assign i_prio = last_d_q;

  // Remember the winner of every conflict cycle; other cycles leave it alone.
  always_comb begin
    last_d_d = last_d_q;
    if (rst_n && i_req && d_req) begin
      last_d_d = d_gnt;
    end
  end

  // Conflict-history register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d_q <= 1'b0;
    end else begin
      last_d_q <= last_d_d;
    end
  end
`else
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_q, starve_d;

  assign i_prio = (starve_q == LIMIT);

  // Count consecutive cycles I is left waiting; any grant or dropped request
  // clears it. Saturates so it can never wrap past the override point.
  always_comb begin
    starve_d = '0;
    if (i_req && !i_gnt) begin
      starve_d = (starve_q == LIMIT) ? starve_q : starve_q + 4'd1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`endif

  // Grant decision: a lone requester always wins; a conflict goes to D unless
  // the priority logic hands it to I. Nothing is granted while in reset.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (rst_n) begin
      if (i_req && d_req) begin
        i_gnt = i_prio;
        d_gnt = !i_prio;
      end else begin
        i_gnt = i_req;
        d_gnt = d_req;
      end
    end
  end

  assign stall_if = i_req & ~i_gnt;

  // Steer the granted request onto the SRAM pins; idle pins are parked at 0.
  always_comb begin
    sram_csn  = 1'b1;
    sram_wen  = 1'b1;
    sram_addr = '0;
    sram_be   = '0;
    sram_di   = '0;
    if (d_gnt) begin
      sram_csn  = 1'b0;
      sram_wen  = ~d_we;
      sram_addr = d_addr;
      sram_be   = d_be;
      sram_di   = d_wdata;
    end else if (i_gnt) begin
      sram_csn  = 1'b0;
      sram_addr = i_addr;
      sram_be   = '1;
    end
  end

  // Record who owns the data arriving next cycle; writes return nothing.
  always_comb begin
    owner_d = NONE;
    if (i_gnt) begin
      owner_d = RESP_I;
    end else if (d_gnt && !d_we) begin
      owner_d = RESP_D;
    end
  end

  // Response-owner state register; reset discards any pending response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // Route SRAM read data to its owner; the other port sees zeros.
  always_comb begin
    i_rvalid = (owner_q == RESP_I);
    d_rvalid = (owner_q == RESP_D);
    i_rdata  = i_rvalid ? sram_dout : '0;
    d_rdata  = d_rvalid ? sram_dout : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: behavioural SRAM model, table of per-cycle
// request vectors with expected grants, and a response scoreboard.
module tb_mem_port_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int BEW = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           i_req, i_gnt, i_rvalid;
  logic [AW-1:0]  i_addr;
  logic [DW-1:0]  i_rdata;
  logic           d_req, d_we, d_gnt, d_rvalid;
  logic [BEW-1:0] d_be;
  logic [AW-1:0]  d_addr;
  logic [DW-1:0]  d_wdata, d_rdata;
  logic           sram_csn, sram_wen;
  logic [AW-1:0]  sram_addr;
  logic [BEW-1:0] sram_be;
  logic [DW-1:0]  sram_di, sram_dout;
  logic           stall_if;

  mem_port_arbiter #(.AW(AW), .DW(DW), .BEW(BEW), .STARVE_LIMIT(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .sram_csn(sram_csn), .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_be(sram_be),
    .sram_di(sram_di), .sram_dout(sram_dout), .stall_if(stall_if)
  );

  always #5 clk = ~clk;

  // Single-port synchronous SRAM with byte enables, 1-cycle read latency.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (!sram_csn) begin
      if (!sram_wen) begin
        for (int b = 0; b < BEW; b++)
          if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_di[8*b +: 8];
      end else begin
        sram_dout <= mem[sram_addr];
      end
    end
  end

  typedef struct packed {
    logic           i_req;
    logic           d_req;
    logic           d_we;
    logic [AW-1:0]  i_addr;
    logic [AW-1:0]  d_addr;
    logic [BEW-1:0] d_be;
    logic [DW-1:0]  d_wdata;
    logic           e_ign;
    logic           e_dgn;
    logic [DW-1:0]  e_rdata;
  } vec_t;

  typedef struct packed {
    logic [1:0]    owner;  // 0 none, 1 I, 2 D
    logic [DW-1:0] data;
  } resp_t;

  vec_t  tbl[$];
  resp_t sb[$];
  int    chk_cnt = 0;
  int    pass_cnt = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
  endtask

  function automatic void add(input logic ir, input logic dr, input logic we,
                              input logic [AW-1:0] ia, input logic [AW-1:0] da,
                              input logic [BEW-1:0] be, input logic [DW-1:0] wd,
                              input logic eig, input logic edg, input logic [DW-1:0] erd);
    vec_t v;
    v = '{i_req: ir, d_req: dr, d_we: we, i_addr: ia, d_addr: da, d_be: be,
          d_wdata: wd, e_ign: eig, e_dgn: edg, e_rdata: erd};
    tbl.push_back(v);
  endfunction

  // Check the response due this cycle against the oldest scoreboard entry.
  task automatic check_resp();
    resp_t r;
    r = '{owner: 2'd0, data: '0};
    if (sb.size() > 0) r = sb.pop_front();
    chk("i_rvalid", {31'd0, i_rvalid}, {31'd0, r.owner == 2'd1});
    chk("d_rvalid", {31'd0, d_rvalid}, {31'd0, r.owner == 2'd2});
    chk("i_rdata", i_rdata, (r.owner == 2'd1) ? r.data : '0);
    chk("d_rdata", d_rdata, (r.owner == 2'd2) ? r.data : '0);
  endtask

  // Apply one vector (called right after a falling edge), check the
  // combinational grant/SRAM outputs, queue the expected response, then
  // check that response at the next falling edge.
  task automatic step(input vec_t v, input int idx);
    resp_t r;
    i_req = v.i_req; d_req = v.d_req; d_we = v.d_we;
    i_addr = v.i_addr; d_addr = v.d_addr; d_be = v.d_be; d_wdata = v.d_wdata;
    #1;
    $display("vec %0d: i_req=%0b d_req=%0b we=%0b -> i_gnt=%0b d_gnt=%0b stall=%0b",
             idx, i_req, d_req, d_we, i_gnt, d_gnt, stall_if);
    chk("i_gnt", {31'd0, i_gnt}, {31'd0, v.e_ign});
    chk("d_gnt", {31'd0, d_gnt}, {31'd0, v.e_dgn});
    chk("stall_if", {31'd0, stall_if}, {31'd0, v.i_req & ~v.e_ign});
    chk("sram_csn", {31'd0, sram_csn}, {31'd0, ~(v.e_ign | v.e_dgn)});
    chk("sram_wen", {31'd0, sram_wen}, {31'd0, ~(v.e_dgn & v.d_we)});
    if (v.e_dgn) begin
      chk("sram_addr_d", {20'd0, sram_addr}, {20'd0, v.d_addr});
      chk("sram_be_d", {28'd0, sram_be}, {28'd0, v.d_be});
      if (v.d_we) chk("sram_di", sram_di, v.d_wdata);
    end else if (v.e_ign) begin
      chk("sram_addr_i", {20'd0, sram_addr}, {20'd0, v.i_addr});
      chk("sram_be_i", {28'd0, sram_be}, 32'hF);
    end else begin
      chk("sram_idle", {sram_di[19:0], sram_addr}, '0);
      chk("sram_be_idle", {28'd0, sram_be}, '0);
    end
    r.owner = v.e_ign ? 2'd1 : ((v.e_dgn && !v.d_we) ? 2'd2 : 2'd0);
    r.data  = v.e_rdata;
    sb.push_back(r);
    @(negedge clk);
    check_resp();
  endtask

  localparam logic [DW-1:0] DI = 32'hCAFEF00D;  // mem[0x030]
  localparam logic [DW-1:0] II = 32'h00500093;  // mem[0x010]

  initial begin
    mem[12'h010] = II;
    mem[12'h030] = DI;
    mem[12'h020] = 32'h11223344;
    mem[12'hFFF] = 32'hA5A50FFF;

    // Conflict run starting at reset release.
`ifdef MEM_ARB_ROUND_ROBIN_EN
    for (int k = 0; k < 4; k++) begin
      add(1, 1, 0, 12'h010, 12'h030, 4'hF, 0, 0, 1, DI);
      add(1, 1, 0, 12'h010, 12'h030, 4'hF, 0, 1, 0, II);
    end
`else
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 3; j++) add(1, 1, 0, 12'h010, 12'h030, 4'hF, 0, 0, 1, DI);
      add(1, 1, 0, 12'h010, 12'h030, 4'hF, 0, 1, 0, II);
    end
`endif
    add(0, 0, 0, 12'h000, 12'h000, 4'h0, 0, 0, 0, 0);                 // idle
    add(1, 0, 0, 12'h010, 12'h000, 4'h0, 0, 1, 0, II);                // lone fetch
    add(1, 0, 0, 12'hFFF, 12'h000, 4'h0, 0, 1, 0, 32'hA5A50FFF);      // top address
    add(0, 1, 1, 12'h000, 12'h020, 4'b0011, 32'hDEADBEEF, 0, 1, 0);   // partial write
    add(0, 1, 0, 12'h000, 12'h020, 4'hF, 0, 0, 1, 32'h1122BEEF);      // read back
    add(1, 0, 0, 12'h020, 12'h000, 4'h0, 0, 1, 0, 32'h1122BEEF);      // back-to-back I
    // I denied, then drops its request, then conflicts again.
`ifdef MEM_ARB_ROUND_ROBIN_EN
    add(1, 1, 0, 12'h010, 12'h030, 4'hF, 0, 0, 1, DI);
    add(1, 1, 0, 12'h010, 12'h030, 4'hF, 0, 1, 0, II);
    add(0, 1, 0, 12'h010, 12'h030, 4'hF, 0, 0, 1, DI);
    add(1, 1, 0, 12'h010, 12'h030, 4'hF, 0, 0, 1, DI);
    add(1, 1, 0, 12'h010, 12'h030, 4'hF, 0, 1, 0, II);
`else
    add(1, 1, 0, 12'h010, 12'h030, 4'hF, 0, 0, 1, DI);
    add(1, 1, 0, 12'h010, 12'h030, 4'hF, 0, 0, 1, DI);
    add(0, 1, 0, 12'h010, 12'h030, 4'hF, 0, 0, 1, DI);
    for (int j = 0; j < 3; j++) add(1, 1, 0, 12'h010, 12'h030, 4'hF, 0, 0, 1, DI);
    add(1, 1, 0, 12'h010, 12'h030, 4'hF, 0, 1, 0, II);
`endif
    add(0, 0, 0, 12'h000, 12'h000, 4'h0, 0, 0, 0, 0);

    // Reset with both ports requesting: nothing may be granted.
    rst_n = 1'b0;
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    i_addr = 12'h010; d_addr = 12'h030; d_be = 4'hF; d_wdata = '0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      $display("reset cycle %0d: i_gnt=%0b d_gnt=%0b csn=%0b wen=%0b", k, i_gnt, d_gnt, sram_csn, sram_wen);
      chk("rst_i_gnt", {31'd0, i_gnt}, 32'd0);
      chk("rst_d_gnt", {31'd0, d_gnt}, 32'd0);
      chk("rst_csn", {31'd0, sram_csn}, 32'd1);
      chk("rst_wen", {31'd0, sram_wen}, 32'd1);
      chk("rst_rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);
      chk("rst_rdata", i_rdata | d_rdata, 32'd0);
    end
    rst_n = 1'b1;

    for (int n = 0; n < tbl.size(); n++) step(tbl[n], n);

    // Reset between a D-read grant and its response: the response is lost.
    d_req = 1'b1; d_we = 1'b0; d_addr = 12'h030; i_req = 1'b0;
    #1;
    chk("rstmid_d_gnt", {31'd0, d_gnt}, 32'd1);
    #1 rst_n = 1'b0;
    @(negedge clk);
    $display("mid-op reset: d_rvalid=%0b (in reset)", d_rvalid);
    chk("rstmid_rvalid_in", {30'd0, i_rvalid, d_rvalid}, 32'd0);
    d_req = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      $display("mid-op reset: d_rvalid=%0b (released %0d)", d_rvalid, k);
      chk("rstmid_rvalid_out", {30'd0, i_rvalid, d_rvalid}, 32'd0);
      chk("rstmid_rdata", d_rdata, 32'd0);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
